// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Turns a raw mechanical push-button into a clean debounced
//               level, with one-cycle press, release and auto-repeat strobes.
//               Structure: two-flop synchroniser, debounce FSM, then an
//               optional auto-repeat counter.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic btn_pulse
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W  = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0]  C_DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [RCNT_W-1:0] C_REP_FIRST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] C_REP_NEXT  = RCNT_W'(REPEAT_PERIOD - 1);
    localparam logic [RCNT_W-1:0] C_RCNT_ONE  = RCNT_W'(1);
    localparam logic              C_INVERT    = (ACTIVE_LOW != 0);
    localparam logic              C_REP_ON    = (REPEAT_EN != 0);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    logic              r_sync0;
    logic              r_sync1;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [RCNT_W-1:0] r_rcnt;
    logic              r_rep_armed;

    logic              w_db_done;
    logic              w_enter_pressed;
    logic              w_hold;
    logic              w_rep_hit;
    logic              w_level_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_repeat_nxt;

    // The counter has seen enough stable samples once it reaches the last value.
    assign w_db_done       = (r_cnt == C_DB_LAST);
    assign w_enter_pressed = (r_state == S_PRESS_CHK) && r_sync1 && w_db_done;
    // Repeat timing only advances while the button is confirmed held.
    assign w_hold          = C_REP_ON && (r_state == S_PRESSED) && r_sync1;
    // First tick waits the long delay; after that the shorter period applies.
    assign w_rep_hit       = w_hold && (r_rcnt == (r_rep_armed ? C_REP_NEXT : C_REP_FIRST));

    // Polarity-normalise the pin, then bring it into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn_in ^ C_INVERT;
            r_sync1 <= r_sync0;
        end
    end

    // State and debounce counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a level change must persist for the full debounce window.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_sync1) begin
                    w_state_nxt = S_PRESS_CHK;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            S_PRESS_CHK: begin
                if (!r_sync1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_db_done) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!r_sync1) begin
                    w_state_nxt = S_RELEASE_CHK;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            S_RELEASE_CHK: begin
                if (r_sync1) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (w_db_done) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        w_level_nxt   = btn_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            S_PRESS_CHK: begin
                if (w_enter_pressed) begin
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end
            end
            S_PRESSED: begin
                w_repeat_nxt = w_rep_hit;
            end
            S_RELEASE_CHK: begin
                if (!r_sync1 && w_db_done) begin
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_level_nxt = btn_level;
            end
        endcase
    end

    // Output registers; reset clears the level without emitting a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            btn_pulse     <= 1'b0;
        end else begin
            btn_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            repeat_pulse  <= w_repeat_nxt;
            btn_pulse     <= w_press_nxt | w_repeat_nxt;
        end
    end

    // Auto-repeat counter: restarts on each accepted press, reloads after each
    // tick, and simply holds while a release is being qualified.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt      <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_enter_pressed) begin
            r_rcnt      <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_hold) begin
            if (w_rep_hit) begin
                r_rcnt      <= '0;
                r_rep_armed <= 1'b1;
            end else begin
                r_rcnt      <= r_rcnt + C_RCNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
